// File: rtl/morse_key_timer.sv
// Telegraph key front end: debounce, press/gap timing, dot/dash/space strobes.
// Define MORSE_KEY_SYNC_EN to add a 2-flop input synchroniser ahead of the debouncer.
module morse_key_timer #(
  parameter int UNIT_CYCLES     = 100,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_SYMS        = 5,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic dot_out,
  output logic dash_out,
  output logic char_space_out,
  output logic word_space_out,
  output logic overflow_out,
  output logic key_busy
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SYM_W = $clog2(MAX_SYMS + 1);

  localparam logic [CNT_W-1:0] DASH_T = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] CHAR_T = CNT_W'(3 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] WORD_T = CNT_W'(7 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP,
    CHAR_GAP
  } state_t;

  state_t state_q, state_d;

  logic key_s;

`ifdef MORSE_KEY_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], key_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign key_s = sync_q[1];
`else
  assign key_s = key_in;
`endif

  logic             key_db_q, key_db_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] dur_q, dur_d, dur_inc;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic             ovf_q, ovf_d;
  logic             dot_q, dot_d;
  logic             dash_q, dash_d;
  logic             char_q, char_d;
  logic             word_q, word_d;

  // A level change is accepted only after DEBOUNCE_CYCLES straight mismatches.
  always_comb begin
    deb_d    = '0;
    key_db_d = key_db_q;
    if (key_s != key_db_q) begin
      if (deb_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        key_db_d = ~key_db_q;
      end else begin
        deb_d = deb_q + DEB_W'(1);
      end
    end
  end

  assign dur_inc = (dur_q == '1) ? dur_q : dur_q + ONE;

  always_comb begin
    state_d = state_q;
    dur_d   = dur_inc;
    sym_d   = sym_q;
    ovf_d   = ovf_q;
    dot_d   = 1'b0;
    dash_d  = 1'b0;
    char_d  = 1'b0;
    word_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_db_q) begin
          state_d = PRESS;
          dur_d   = ONE;
        end
      end
      PRESS: begin
        if (!key_db_q) begin
          if (sym_q < SYM_W'(MAX_SYMS)) begin
            dash_d = (dur_q >= DASH_T);
            dot_d  = (dur_q < DASH_T);
            sym_d  = sym_q + SYM_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
          state_d = GAP;
          dur_d   = ONE;
        end
      end
      GAP: begin
        if (dur_q == CHAR_T) begin
          char_d  = 1'b1;
          sym_d   = '0;
          ovf_d   = 1'b0;
          state_d = CHAR_GAP;
        end
        // a rise on the threshold cycle still lets the strobe out
        if (key_db_q) begin
          state_d = PRESS;
          dur_d   = ONE;
        end
      end
      CHAR_GAP: begin
        if (dur_q == WORD_T) begin
          word_d  = 1'b1;
          state_d = IDLE;
        end
        if (key_db_q) begin
          state_d = PRESS;
          dur_d   = ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      key_db_q <= 1'b0;
      deb_q    <= '0;
      dur_q    <= '0;
      sym_q    <= '0;
      ovf_q    <= 1'b0;
      dot_q    <= 1'b0;
      dash_q   <= 1'b0;
      char_q   <= 1'b0;
      word_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_db_q <= key_db_d;
      deb_q    <= deb_d;
      dur_q    <= dur_d;
      sym_q    <= sym_d;
      ovf_q    <= ovf_d;
      dot_q    <= dot_d;
      dash_q   <= dash_d;
      char_q   <= char_d;
      word_q   <= word_d;
    end
  end

  assign dot_out        = dot_q;
  assign dash_out       = dash_q;
  assign char_space_out = char_q;
  assign word_space_out = word_q;
  assign overflow_out   = ovf_q;
  assign key_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_morse_key_timer.sv
// Bench for morse_key_timer: event-timing reference model plus directed key patterns.
// Build with MORSE_KEY_SYNC_EN defined to cover the synchronised variant.
module tb_morse_key_timer;

  localparam int UNIT   = 4;
  localparam int DEB    = 2;
  localparam int MAXS   = 5;
  localparam int CW     = 16;
  localparam int DASH_T = 2 * UNIT;
  localparam int CHAR_T = 3 * UNIT;
  localparam int WORD_T = 7 * UNIT;
`ifdef MORSE_KEY_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_in = 1'b0;
  logic dot_out, dash_out, char_space_out, word_space_out;
  logic overflow_out, key_busy;

  morse_key_timer #(
    .UNIT_CYCLES(UNIT),
    .DEBOUNCE_CYCLES(DEB),
    .MAX_SYMS(MAXS),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_in(key_in),
    .dot_out(dot_out),
    .dash_out(dash_out),
    .char_space_out(char_space_out),
    .word_space_out(word_space_out),
    .overflow_out(overflow_out),
    .key_busy(key_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // reference model: debounced level from a sample window, events from run lengths
  bit kp0, kp1, ks;
  bit hist [DEB];
  bit all_diff;
  bit mdb, mdb_prev, rise, fall;
  int rise_t, fall_t, d, syms;
  bit pressing, gap_live, char_done, ovf;
  bit started = 1'b0;
  bit c_dot, c_dash, c_char, c_word, c_ovf, c_busy;
  bit n_dot, n_dash, n_char, n_word, n_ovf, n_busy;

  always @(posedge clk) begin
    cyc++;
    {c_dot, c_dash, c_char, c_word, c_ovf, c_busy} =
      {n_dot, n_dash, n_char, n_word, n_ovf, n_busy};
    {n_dot, n_dash, n_char, n_word} = 4'b0;
    if (rst) begin
      started = 1'b1;
      {c_dot, c_dash, c_char, c_word, c_ovf, c_busy} = 6'b0;
      {n_ovf, n_busy} = 2'b0;
      kp0 = 1'b0;
      kp1 = 1'b0;
      for (int i = 0; i < DEB; i++) hist[i] = 1'b0;
      mdb = 1'b0;
      mdb_prev = 1'b0;
      pressing = 1'b0;
      gap_live = 1'b0;
      char_done = 1'b0;
      ovf = 1'b0;
      syms = 0;
    end else begin
`ifdef MORSE_KEY_SYNC_EN
      ks = kp1;
      kp1 = kp0;
      kp0 = key_in;
`else
      ks = key_in;
`endif
      for (int i = DEB - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = ks;
      all_diff = 1'b1;
      for (int i = 0; i < DEB; i++) if (hist[i] == mdb) all_diff = 1'b0;
      mdb_prev = mdb;
      if (all_diff) mdb = ~mdb;
      rise = mdb && !mdb_prev;
      fall = !mdb && mdb_prev;
      if (gap_live) begin
        d = cyc - fall_t;
        if (d == CHAR_T && !char_done) begin
          n_char = 1'b1;
          syms = 0;
          ovf = 1'b0;
          char_done = 1'b1;
        end else if (d == WORD_T && char_done) begin
          n_word = 1'b1;
          gap_live = 1'b0;
        end
      end
      if (rise) begin
        rise_t = cyc;
        pressing = 1'b1;
        gap_live = 1'b0;
      end
      if (fall && pressing) begin
        if (syms < MAXS) begin
          if (cyc - rise_t >= DASH_T) n_dash = 1'b1;
          else n_dot = 1'b1;
          syms++;
        end else begin
          ovf = 1'b1;
        end
        fall_t = cyc;
        gap_live = 1'b1;
        char_done = 1'b0;
        pressing = 1'b0;
      end
      n_ovf = ovf;
      n_busy = pressing || gap_live;
    end
  end

  task automatic cmp(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  int n_dot_s = 0, n_dash_s = 0, n_char_s = 0, n_word_s = 0;
  int dot_at = -1, char_at = -1, word_at = -1;
  bit busy_seen = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      cmp("dot", dot_out, c_dot);
      cmp("dash", dash_out, c_dash);
      cmp("char", char_space_out, c_char);
      cmp("word", word_space_out, c_word);
      cmp("ovf", overflow_out, c_ovf);
      cmp("busy", key_busy, c_busy);
      if (dot_out === 1'b1) begin n_dot_s++; dot_at = cyc; end
      if (dash_out === 1'b1) n_dash_s++;
      if (char_space_out === 1'b1) begin n_char_s++; char_at = cyc; end
      if (word_space_out === 1'b1) begin n_word_s++; word_at = cyc; end
      if (key_busy === 1'b1) busy_seen = 1'b1;
    end
  end

  task automatic hold(input bit v, input int n);
    key_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int b_dot, b_dash, b_char, b_word, f0;

  task automatic snap();
    b_dot = n_dot_s;
    b_dash = n_dash_s;
    b_char = n_char_s;
    b_word = n_word_s;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single dot, then full silence: pin absolute latencies
    snap();
    hold(1'b1, 4);
    f0 = cyc;
    hold(1'b0, 40);
    chk("t1_dot_cyc", dot_at, f0 + 3 + SL);
    chk("t1_char_cyc", char_at, f0 + 15 + SL);
    chk("t1_word_cyc", word_at, f0 + 31 + SL);
    chk("t1_dots", n_dot_s - b_dot, 1);
    chk("t1_dash", n_dash_s - b_dash, 0);
    chk("t1_busy_end", int'(key_busy), 0);

    // dot/dash boundary
    snap();
    hold(1'b1, DASH_T - 1);
    hold(1'b0, 5);
    hold(1'b1, DASH_T);
    hold(1'b0, 40);
    chk("t2_dot", n_dot_s - b_dot, 1);
    chk("t2_dash", n_dash_s - b_dash, 1);
    chk("t2_char", n_char_s - b_char, 1);

    // glitch and bounce
    snap();
    busy_seen = 1'b0;
    hold(1'b1, 1);
    hold(1'b0, 10);
    chk("t3_glitch_busy", int'(busy_seen), 0);
    chk("t3_glitch_sym", n_dot_s + n_dash_s - b_dot - b_dash, 0);
    for (int i = 0; i < 10; i++) hold(i % 2 == 0, 1);
    hold(1'b1, 8);
    hold(1'b0, 40);
    chk("t3_bounce_dash", n_dash_s - b_dash, 1);
    chk("t3_bounce_dot", n_dot_s - b_dot, 0);

    // gap CHAR_T-1 is still inside the character
    snap();
    hold(1'b1, 4);
    hold(1'b0, CHAR_T - 1);
    hold(1'b1, 4);
    hold(1'b0, 40);
    chk("t4_dots", n_dot_s - b_dot, 2);
    chk("t4_char", n_char_s - b_char, 1);
    chk("t4_word", n_word_s - b_word, 1);

    // overflow on the sixth symbol
    snap();
    for (int i = 0; i < 6; i++) begin
      hold(1'b1, 4);
      hold(1'b0, 4);
    end
    hold(1'b0, 4);
    chk("t5_ovf_set", int'(overflow_out), 1);
    chk("t5_dots", n_dot_s - b_dot, 5);
    hold(1'b0, 40);
    chk("t5_ovf_clr", int'(overflow_out), 0);
    chk("t5_char", n_char_s - b_char, 1);

    // rise on the CHAR_T cycle: char strobe still fires
    snap();
    hold(1'b1, 4);
    hold(1'b0, CHAR_T);
    hold(1'b1, 4);
    hold(1'b0, 40);
    chk("tb_dots", n_dot_s - b_dot, 2);
    chk("tb_char", n_char_s - b_char, 2);
    chk("tb_word", n_word_s - b_word, 1);

    // reset in the middle of a press
    snap();
    hold(1'b1, 4);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_outs_zero",
        int'({dot_out, dash_out, char_space_out, word_space_out, overflow_out, key_busy}), 0);
    hold(1'b1, 1);
    hold(1'b0, 40);
    chk("t6_no_sym", n_dot_s + n_dash_s - b_dot - b_dash, 0);

    // key held through reset release counts as a fresh press
    snap();
    rst = 1'b1;
    key_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    hold(1'b1, 10);
    hold(1'b0, 40);
    chk("t7_dash", n_dash_s - b_dash, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_key_timer.md
Name: morse_key_timer

Overview:
- Upstream front end for the Morse translator. Converts a single raw telegraph key (one button) into the four one-cycle symbol strobes that the translator FSM consumes: dot, dash, char space and word space.
- Debounces the key, times press and release durations in units of a configurable dot period, and classifies each event.
- Also enforces a per-character symbol limit and flags overflow.

Parameters:
- UNIT_CYCLES, 100, clock cycles per Morse time unit (one dot length).
- DEBOUNCE_CYCLES, 4, cycles the raw key must hold a new level before the debounced level changes (≥1).
- MAX_SYMS, 5, maximum dots plus dashes accepted per character.
- CNT_W, 16, width of the duration counter. Must satisfy 2^CNT_W − 1 ≥ 7*UNIT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_in  in  1  raw key level; 1 = pressed.
- dot_out  out  1  one-cycle strobe: dot recognised.
- dash_out  out  1  one-cycle strobe: dash recognised.
- char_space_out  out  1  one-cycle strobe: inter-character gap reached.
- word_space_out  out  1  one-cycle strobe: inter-word gap reached.
- overflow_out  out  1  sticky: symbol beyond MAX_SYMS discarded in current character.
- key_busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high. On rst, at the next edge:
  - all outputs = 0, state = IDLE;
  - key_db = 0, dur_cnt = 0, deb_cnt = 0, sym_cnt = 0.
- Debounce:
  - deb_cnt counts consecutive cycles where the key sample ≠ key_db; it clears on any match.
  - When deb_cnt reaches DEBOUNCE_CYCLES, key_db toggles and deb_cnt clears.
  - For a clean input, key_db lags key_in by exactly DEBOUNCE_CYCLES cycles.
  - Pulses shorter than DEBOUNCE_CYCLES are invisible.
- dur_cnt counts cycles since the last key_db transition. It saturates at 2^CNT_W − 1 and never wraps.
- Thresholds:
  - DASH_T = 2*UNIT_CYCLES
  - CHAR_T = 3*UNIT_CYCLES
  - WORD_T = 7*UNIT_CYCLES
- States and transitions:
  - IDLE: waits for key_db rise → PRESS, dur_cnt = 1. No strobes are ever generated from IDLE, so reset never yields spurious spaces.
  - PRESS: dur_cnt increments while key_db = 1. On the first cycle key_db = 0, let L = dur_cnt (the press length):
    - L ≥ DASH_T → dash, else dot.
    - If sym_cnt < MAX_SYMS: strobe the symbol on the next cycle and increment sym_cnt.
    - Otherwise: emit no strobe and set overflow_out.
    - Go to GAP with dur_cnt = 1.
  - GAP: dur_cnt increments while key_db = 0.
    - key_db rise → PRESS; no space strobe (intra-character gap).
    - dur_cnt reaching CHAR_T → char_space_out strobe; sym_cnt = 0; overflow_out cleared; go to CHAR_GAP.
  - CHAR_GAP: counting continues.
    - key_db rise → PRESS.
    - dur_cnt reaching WORD_T → word_space_out strobe; go to IDLE.
- Output rules:
  - All strobes are registered, exactly one cycle wide, and mutually exclusive (at most one per cycle).
  - Dot/dash latency from the raw key falling edge (clean input) is DEBOUNCE_CYCLES + 1 cycles.
- Boundary cases:
  - Press exactly DASH_T − 1 cycles → dot; exactly DASH_T → dash.
  - Gap exactly CHAR_T − 1 cycles then press → no char_space.
  - A key rise in the same cycle the CHAR_T or WORD_T threshold is hit: the strobe still fires, then the FSM enters PRESS.
  - Key held through reset release: treated as a new press, timed from the debounced rise.
  - rst mid-PRESS: that press produces no strobe.

Optional Feature:
- Macro: MORSE_KEY_SYNC_EN.
- Defined: key_in passes through a 2-flop synchroniser before the debouncer. All key-to-strobe latencies increase by 2 cycles. The synchroniser flops reset to 0.
- Undefined: key_in is sampled directly by the debouncer (the source must already be synchronous to clk).
- Classification and thresholds are identical in both builds.

Test Plan (UNIT_CYCLES=4, DEBOUNCE_CYCLES=2, MAX_SYMS=5, macro undefined unless stated):
1. key_in high 4 cycles, then low indefinitely → dot_out pulse 3 cycles after the fall; char_space_out when gap = 12; word_space_out when gap = 28; key_busy then 0; no other strobes.
2. Press 7 cycles → dot_out; press 8 cycles → dash_out; each is exactly one cycle wide.
3. key_in high 1 cycle amid low → no strobes, key_busy stays 0. Bouncing 1-cycle high/low for 10 cycles then held high 8 → single dash_out.
4. Dot, gap 11 cycles, dot, long gap → two dot_out pulses, one char_space_out, one word_space_out.
5. Six dots with 4-cycle gaps → five dot_out pulses; overflow_out = 1 after the sixth release; it clears with the char_space_out strobe.
6. rst asserted for 1 cycle during a 6-cycle press → all outputs 0 the next cycle; no dot_out on release. Repeat with MORSE_KEY_SYNC_EN defined → case 1 latencies become +2.
